// File: rtl/tx_pattern_shifter.sv
// tx_pattern_shifter
// Transmit-side pattern serialiser. The host loads six samples into addressable
// slots while the block is idle, using the same 3-bit slot-select encoding as the
// receive-side readback. After commit, the block emits one slot per txstrobe on
// out_sample, starting with slot0. It pulses done on the strobe that follows the
// last sample.
//
// Optional build macro: TX_PATTERN_LOOP_EN. When it is defined, the pattern
// repeats from slot0 after slot5, and out_valid stays high until abort or reset.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   txstrobe   one-cycle sample-rate strobe from the TX path
//   wr_en      slot write enable (honoured only in IDLE)
//   sel        3-bit slot select for writes
//   wr_data    sample to write
//   commit     start transmitting the loaded pattern
//   abort      end any run and return to IDLE (highest priority)
//   out_sample registered sample to the TX path (IDLE_VALUE when not valid)
//   out_valid  out_sample holds a pattern sample
//   busy       state is ARMED or SHIFTING
//   done       one-cycle pulse at end of pattern
module tx_pattern_shifter #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             txstrobe,
    input  logic             wr_en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             commit,
    input  logic             abort,
    output logic [WIDTH-1:0] out_sample,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFTING} state_t;

    state_t                 state;
    logic [5:0][WIDTH-1:0]  slots;
    logic [2:0]             idx;
    logic [2:0]             wr_slot;
    logic [WIDTH-1:0]       rd_sample;

    // sel[2:1] picks the slot pair and sel[0] picks the slot within that pair.
    // The unused codes 0 and 3 both select the slot4/slot5 pair.
    always_comb begin
        wr_slot = {2'b10, sel[0]};
        case (sel[2:1])
            2'd1:    wr_slot = {2'b00, sel[0]};
            2'd2:    wr_slot = {2'b01, sel[0]};
            default: wr_slot = {2'b10, sel[0]};
        endcase
    end

    // Read mux for the next sample. idx is only used here while it is in 1..5.
    always_comb begin
        rd_sample = slots[0];
        for (int i = 0; i < 6; i++)
            if (idx == 3'(i)) rd_sample = slots[i];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slots      <= '0;
            idx        <= '0;
            out_sample <= IDLE_VALUE;
            out_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                idx        <= '0;
                out_sample <= IDLE_VALUE;
                out_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A write in the commit cycle lands before the first strobe
                        // can read it, so the new value is the one transmitted.
                        if (wr_en) slots[wr_slot] <= wr_data;
                        if (commit) state <= ARMED;
                    end
                    ARMED: begin
                        if (txstrobe) begin
                            out_sample <= slots[0];
                            out_valid  <= 1'b1;
                            idx        <= 3'd1;
                            state      <= SHIFTING;
                        end
                    end
                    SHIFTING: begin
                        if (txstrobe) begin
                            if (idx < 3'd6) begin
                                out_sample <= rd_sample;
                                idx        <= idx + 3'd1;
                            end else begin
                                done <= 1'b1;
`ifdef TX_PATTERN_LOOP_EN
                                out_sample <= slots[0];
                                idx        <= 3'd1;
`else
                                out_sample <= IDLE_VALUE;
                                out_valid  <= 1'b0;
                                idx        <= '0;
                                state      <= IDLE;
`endif
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_pattern_shifter.sv
// Testbench for tx_pattern_shifter. It checks table-driven vectors, a set of
// directed corner sequences, and randomized traffic. Every cycle is compared
// against a pattern-level reference model that counts strobes since commit.
module tb_tx_pattern_shifter;

    logic       clk = 1'b0;
    logic       reset, txstrobe, wr_en, commit, abort;
    logic [2:0] sel;
    logic [7:0] wr_data, out_sample;
    logic       out_valid, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tx_pattern_shifter #(.WIDTH(8), .IDLE_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .txstrobe(txstrobe), .wr_en(wr_en), .sel(sel),
        .wr_data(wr_data), .commit(commit), .abort(abort), .out_sample(out_sample),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_slot [6];
    logic [7:0] m_pat  [6];
    bit         m_act;
    int         m_cnt;
    logic [7:0] e_sample;
    bit         e_valid, e_done;

    function automatic int slot_of(logic [2:0] s);
        case (s[2:1])
            2'd1:    return 0 + int'(s[0]);
            2'd2:    return 2 + int'(s[0]);
            default: return 4 + int'(s[0]);
        endcase
    endfunction

    task automatic model(input bit w, input logic [2:0] s, input logic [7:0] d,
                         input bit c, input bit t, input bit a, input bit r);
        e_done = 0;
        if (r) begin
            foreach (m_slot[i]) m_slot[i] = 8'h00;
            m_act = 0; m_cnt = 0; e_sample = 8'h00; e_valid = 0;
        end else if (a) begin
            m_act = 0; e_sample = 8'h00; e_valid = 0;
        end else if (!m_act) begin
            if (w) m_slot[slot_of(s)] = d;
            if (c) begin
                m_act = 1; m_cnt = 0;
                foreach (m_pat[i]) m_pat[i] = m_slot[i];
            end
        end else if (t) begin
            m_cnt++;
`ifdef TX_PATTERN_LOOP_EN
            e_sample = m_pat[(m_cnt - 1) % 6];
            e_valid  = 1;
            e_done   = (m_cnt > 1) && ((m_cnt - 1) % 6 == 0);
`else
            if (m_cnt <= 6) begin
                e_sample = m_pat[m_cnt - 1]; e_valid = 1;
            end else begin
                e_sample = 8'h00; e_valid = 0; e_done = 1; m_act = 0;
            end
`endif
        end
    endtask

    task automatic check(input string name, input logic [7:0] xs, input bit xv,
                         input bit xb, input bit xd);
        tests++;
        if (out_sample !== xs || out_valid !== xv || busy !== xb || done !== xd) begin
            fails++;
            $display("FAIL %s t=%0t: got sample=%h valid=%b busy=%b done=%b, want sample=%h valid=%b busy=%b done=%b",
                     name, $time, out_sample, out_valid, busy, done, xs, xv, xb, xd);
        end
    endtask

    // Applies one cycle of inputs, advances the model, and compares the outputs
    // just after the edge.
    task automatic step(input string name, input bit w, input logic [2:0] s,
                        input logic [7:0] d, input bit c, input bit t, input bit a,
                        input bit r);
        wr_en = w; sel = s; wr_data = d; commit = c; txstrobe = t; abort = a; reset = r;
        @(posedge clk);
        model(w, s, d, c, t, a, r);
        #1;
        check(name, e_sample, e_valid, m_act, e_done);
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) step(name, 0, 3'd0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic strobe(input string name);
        step(name, 0, 3'd0, 8'h00, 0, 1, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         w;
        logic [2:0] s;
        logic [7:0] d;
        bit         c, t;
        logic [7:0] xs;
        bit         xv, xb, xd;
    } vec_t;

    vec_t vt [$];

    initial begin
        vec_t v;
        logic [2:0] wsel [6];
        wsel[0] = 3'd2; wsel[1] = 3'd3; wsel[2] = 3'd4;
        wsel[3] = 3'd5; wsel[4] = 3'd0; wsel[5] = 3'd1;

        // Load slot0..slot5 with 0x11..0x66, commit, then send 7 strobes 4 cycles apart.
        for (int i = 0; i < 6; i++) begin
            v = '{w:1, s:wsel[i], d:8'(8'h11 * (i + 1)), c:0, t:0, xs:8'h00, xv:0, xb:0, xd:0};
            vt.push_back(v);
        end
        v = '{w:0, s:3'd0, d:8'h00, c:1, t:0, xs:8'h00, xv:0, xb:1, xd:0};
        vt.push_back(v);
        for (int k = 1; k <= 7; k++) begin
            for (int h = 0; h < 4; h++) begin
                v = '{w:0, s:3'd0, d:8'h00, c:0, t:(h == 0), xs:8'h00, xv:0, xb:0, xd:0};
                if (k <= 6) begin
                    v.xs = 8'(8'h11 * k); v.xv = 1; v.xb = 1;
                end else begin
`ifdef TX_PATTERN_LOOP_EN
                    v.xs = 8'h11; v.xv = 1; v.xb = 1;
`endif
                    v.xd = (h == 0);
                end
                vt.push_back(v);
            end
        end

        // Reset
        step("reset0", 0, 3'd0, 8'h00, 0, 0, 0, 1);
        step("reset1", 0, 3'd0, 8'h00, 0, 0, 0, 1);
        check("reset_const", 8'h00, 0, 0, 0);

        foreach (vt[i]) begin
            step("vec_model", vt[i].w, vt[i].s, vt[i].d, vt[i].c, vt[i].t, 0, 0);
            check($sformatf("vec%0d", i), vt[i].xs, vt[i].xv, vt[i].xb, vt[i].xd);
        end
        step("abort_clr", 0, 3'd0, 8'h00, 0, 0, 1, 0);
        check("abort_clr_const", 8'h00, 0, 0, 0);

        // A txstrobe in the commit cycle is not consumed.
        step("commit_strobe", 0, 3'd0, 8'h00, 1, 1, 0, 0);
        check("commit_strobe_const", 8'h00, 0, 1, 0);
        strobe("first_after_commit");
        check("first_after_commit_const", 8'h11, 1, 1, 0);

        // A write while shifting is ignored.
        step("wr_while_shift", 1, 3'd2, 8'hAA, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin strobe("drain"); idle("drain_gap", 1); end
        check("drained_const", 8'h00, 0, 0, 0);
        step("commit2", 0, 3'd0, 8'h00, 1, 0, 0, 0);
        strobe("slot0_kept");
        check("slot0_kept_const", 8'h11, 1, 1, 0);

        // Abort after the 3rd strobe.
        strobe("s2"); strobe("s3");
        check("s3_const", 8'h33, 1, 1, 0);
        step("abort", 0, 3'd0, 8'h00, 1, 1, 1, 0);
        check("abort_const", 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin strobe("post_abort"); check("post_abort_const", 8'h00, 0, 0, 0); end
        step("recommit", 0, 3'd0, 8'h00, 1, 0, 0, 0);
        strobe("restart");
        check("restart_const", 8'h11, 1, 1, 0);

        // A write and a commit in the same cycle: the new value is transmitted.
        step("abort3", 0, 3'd0, 8'h00, 0, 0, 1, 0);
        step("wr_commit", 1, 3'd2, 8'h5A, 1, 0, 0, 0);
        strobe("wr_commit_s1");
        check("wr_commit_const", 8'h5A, 1, 1, 0);

        // Reset in the middle of a run clears the slots.
        strobe("pre_reset");
        step("mid_reset", 0, 3'd0, 8'h00, 0, 1, 0, 1);
        check("mid_reset_const", 8'h00, 0, 0, 0);
        step("commit_zero", 0, 3'd0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            strobe("zero_run");
            check("zero_run_const", 8'h00, 1, 1, 0);
        end
        strobe("zero_end");

`ifdef TX_PATTERN_LOOP_EN
        // 13 strobes: done follows strobes 7 and 13, and out_valid never drops.
        step("abort_l", 0, 3'd0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step("ld", 1, wsel[i], 8'(8'h10 + i), 0, 0, 0, 0);
        step("commit_l", 0, 3'd0, 8'h00, 1, 0, 0, 0);
        for (int k = 1; k <= 13; k++) begin
            strobe("loop");
            check($sformatf("loop_s%0d", k), 8'(8'h10 + (k - 1) % 6), 1, 1, (k == 7 || k == 13));
            idle("loop_gap", 1);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step("rand",
                 ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
